// File: rtl/operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage
//
// Operand stage between the register file read ports and the ALU. The incoming
// instruction's source addresses go straight out to the register file (RA1/RA2).
// The returned read data (RD1/RD2) is captured in the same cycle, together with
// the opcode, immediate and destination address. A writeback in that cycle
// bypasses the read data.
//
// Captured operands go to the ALU through a valid/ready handshake. The stage has
// two entries: the output register and one skid entry. Because of the skid
// entry, in_ready depends only on state flops and has no combinational path
// from the inputs.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. Once out_valid is high it stays high, and the output fields
// stay unchanged, until out_ready is seen. The only exceptions are FLUSH and
// writeback snoop updates.
//
// Ports:
//   CLK, RST_N                      clock, asynchronous active-low reset
//   in_valid/in_ready               decoder-side handshake
//   in_src1/in_src2/in_dst/in_op/in_imm   decoded instruction fields
//   RA1/RA2 -> regfile, RD1/RD2 <- regfile (combinational read)
//   WB_WE/WB_WA/WB_WD               writeback port (also drives regfile write)
//   FLUSH                           synchronous kill of all held entries
//   out_valid/out_ready             ALU-side handshake
//   out_a/out_b/out_dst/out_op/out_imm    operands and fields to the ALU
// -----------------------------------------------------------------------------
module operand_fetch_stage #(
    parameter int DW  = 8,
    parameter int AW  = 3,
    parameter int OPW = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [AW-1:0]  in_src1,
    input  logic [AW-1:0]  in_src2,
    input  logic [AW-1:0]  in_dst,
    input  logic [OPW-1:0] in_op,
    input  logic [DW-1:0]  in_imm,
    output logic [AW-1:0]  RA1,
    output logic [AW-1:0]  RA2,
    input  logic [DW-1:0]  RD1,
    input  logic [DW-1:0]  RD2,
    input  logic           WB_WE,
    input  logic [AW-1:0]  WB_WA,
    input  logic [DW-1:0]  WB_WD,
    input  logic           FLUSH,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_a,
    output logic [DW-1:0]  out_b,
    output logic [AW-1:0]  out_dst,
    output logic [OPW-1:0] out_op,
    output logic [DW-1:0]  out_imm
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // nothing held
        ST_ONE   = 2'd1,   // output register valid, skid empty
        ST_FULL  = 2'd2    // output register and skid both valid
    } state_t;

    state_t state, state_nx;

    logic accept;
    logic load_out_in;    // output register loads from the input
    logic load_out_skid;  // output register loads from the skid entry
    logic load_skid;      // skid entry loads from the input

    // Source addresses are kept beside each held entry so that later
    // writebacks can still reach the operands.
    logic [AW-1:0]  out_s1, out_s2;
    logic [DW-1:0]  sk_a, sk_b, sk_imm;
    logic [AW-1:0]  sk_s1, sk_s2, sk_dst;
    logic [OPW-1:0] sk_op;

    logic [DW-1:0]  cap_a, cap_b;

    assign RA1 = in_src1;
    assign RA2 = in_src2;

    // Both handshake outputs are decoded from the state register only.
    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (state != ST_FULL);

    // Operand value at capture. Register 0 always reads as zero. A writeback
    // to the same register in this cycle takes priority over the regfile data.
    function automatic logic [DW-1:0] capture(
        input logic [AW-1:0] src,
        input logic [DW-1:0] rd,
        input logic          we,
        input logic [AW-1:0] wa,
        input logic [DW-1:0] wd
    );
        if (src == '0)
            return '0;
        else if (we && (wa == src))
            return wd;
        else
            return rd;
    endfunction

    // Operand value for an entry that is held: a later writeback to its
    // nonzero source register replaces the operand.
    function automatic logic [DW-1:0] snoop(
        input logic [DW-1:0] val,
        input logic [AW-1:0] src,
        input logic          we,
        input logic [AW-1:0] wa,
        input logic [DW-1:0] wd
    );
        if (we && (src != '0) && (wa == src))
            return wd;
        else
            return val;
    endfunction

    assign cap_a = capture(in_src1, RD1, WB_WE, WB_WA, WB_WD);
    assign cap_b = capture(in_src2, RD2, WB_WE, WB_WA, WB_WD);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= ST_EMPTY;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        accept        = in_valid && in_ready && !FLUSH;

        if (FLUSH) begin
            // FLUSH wins over any input handshake and any out_ready.
            state_nx = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        load_out_in = 1'b1;
                        state_nx    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (out_ready && accept) begin
                        load_out_in = 1'b1;
                        state_nx    = ST_ONE;
                    end else if (out_ready) begin
                        state_nx    = ST_EMPTY;
                    end else if (accept) begin
                        load_skid   = 1'b1;
                        state_nx    = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        load_out_skid = 1'b1;
                        state_nx      = ST_ONE;
                    end
                end
                default: state_nx = ST_EMPTY;
            endcase
        end
    end

    // ----------------------------------------------------------- datapath
    // When an entry is not reloaded it is snooped. If the entry is leaving,
    // or is not valid, the snoop result is never observed, so it needs no
    // separate qualification.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_a   <= '0;
            out_b   <= '0;
            out_dst <= '0;
            out_op  <= '0;
            out_imm <= '0;
            out_s1  <= '0;
            out_s2  <= '0;
            sk_a    <= '0;
            sk_b    <= '0;
            sk_dst  <= '0;
            sk_op   <= '0;
            sk_imm  <= '0;
            sk_s1   <= '0;
            sk_s2   <= '0;
        end else begin
            if (load_out_in) begin
                out_a   <= cap_a;
                out_b   <= cap_b;
                out_dst <= in_dst;
                out_op  <= in_op;
                out_imm <= in_imm;
                out_s1  <= in_src1;
                out_s2  <= in_src2;
            end else if (load_out_skid) begin
                // The entry moving from skid to output still sees this
                // edge's writeback.
                out_a   <= snoop(sk_a, sk_s1, WB_WE, WB_WA, WB_WD);
                out_b   <= snoop(sk_b, sk_s2, WB_WE, WB_WA, WB_WD);
                out_dst <= sk_dst;
                out_op  <= sk_op;
                out_imm <= sk_imm;
                out_s1  <= sk_s1;
                out_s2  <= sk_s2;
            end else begin
                out_a   <= snoop(out_a, out_s1, WB_WE, WB_WA, WB_WD);
                out_b   <= snoop(out_b, out_s2, WB_WE, WB_WA, WB_WD);
            end

            if (load_skid) begin
                sk_a   <= cap_a;
                sk_b   <= cap_b;
                sk_dst <= in_dst;
                sk_op  <= in_op;
                sk_imm <= in_imm;
                sk_s1  <= in_src1;
                sk_s2  <= in_src2;
            end else begin
                sk_a   <= snoop(sk_a, sk_s1, WB_WE, WB_WA, WB_WD);
                sk_b   <= snoop(sk_b, sk_s2, WB_WE, WB_WA, WB_WD);
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch_stage
//
// Testbench for operand_fetch_stage. Directed scenario tasks cover reset,
// bypass, backpressure, snoop, flush and asynchronous reset. They are followed
// by a randomized run that is checked against a queue-based reference model of
// the held instructions.
// -----------------------------------------------------------------------------
module tb_operand_fetch_stage;

    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int OPW = 4;

    // ---------------------------------------------------- clock / reset
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    logic           in_valid, in_ready;
    logic [AW-1:0]  in_src1, in_src2, in_dst;
    logic [OPW-1:0] in_op;
    logic [DW-1:0]  in_imm;
    logic [AW-1:0]  RA1, RA2;
    logic [DW-1:0]  RD1, RD2;
    logic           WB_WE;
    logic [AW-1:0]  WB_WA;
    logic [DW-1:0]  WB_WD;
    logic           FLUSH;
    logic           out_valid, out_ready;
    logic [DW-1:0]  out_a, out_b, out_imm;
    logic [AW-1:0]  out_dst;
    logic [OPW-1:0] out_op;

    operand_fetch_stage #(.DW(DW), .AW(AW), .OPW(OPW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst),
        .in_op(in_op), .in_imm(in_imm),
        .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
        .WB_WE(WB_WE), .WB_WA(WB_WA), .WB_WD(WB_WD),
        .FLUSH(FLUSH),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_dst(out_dst),
        .out_op(out_op), .out_imm(out_imm)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ------------------------------------------------ reference model
    // The stage is modelled as an ordered list of at most two held
    // instructions. The head is what the ALU sees.
    typedef struct packed {
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic [AW-1:0]  s1;
        logic [AW-1:0]  s2;
        logic [AW-1:0]  dst;
        logic [OPW-1:0] op;
        logic [DW-1:0]  imm;
    } ent_t;

    ent_t exp_q[$];

    task automatic model_edge();
        ent_t e;
        int   held;
        bit   take;
        if (FLUSH) begin
            exp_q.delete();
            return;
        end
        held = exp_q.size();
        take = in_valid && (held < 2);
        if (out_ready && held > 0)
            void'(exp_q.pop_front());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (WB_WE && WB_WA != 0) begin
                if (exp_q[i].s1 == WB_WA) exp_q[i].a = WB_WD;
                if (exp_q[i].s2 == WB_WA) exp_q[i].b = WB_WD;
            end
        end
        if (take) begin
            e.s1  = in_src1;
            e.s2  = in_src2;
            e.dst = in_dst;
            e.op  = in_op;
            e.imm = in_imm;
            e.a   = (in_src1 == 0) ? '0 : ((WB_WE && WB_WA == in_src1) ? WB_WD : RD1);
            e.b   = (in_src2 == 0) ? '0 : ((WB_WE && WB_WA == in_src2) ? WB_WD : RD2);
            exp_q.push_back(e);
        end
    endtask

    // ------------------------------------------------------ driver tasks
    task automatic drive_idle();
        in_valid = 0; in_src1 = 0; in_src2 = 0; in_dst = 0; in_op = 0; in_imm = 0;
        RD1 = 0; RD2 = 0; WB_WE = 0; WB_WA = 0; WB_WD = 0; FLUSH = 0; out_ready = 0;
    endtask

    task automatic drive_instr(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                               input logic [AW-1:0] d, input logic [OPW-1:0] op,
                               input logic [DW-1:0] imm, input logic [DW-1:0] rd1,
                               input logic [DW-1:0] rd2);
        in_valid = 1; in_src1 = s1; in_src2 = s2; in_dst = d; in_op = op;
        in_imm = imm; RD1 = rd1; RD2 = rd2;
    endtask

    // One rising edge. The model advances with the inputs present at the edge,
    // and outputs are then sampled 1 time unit later.
    task automatic cycle();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        RST_N = 0;
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1;
    endtask

    // ---------------------------------------------------------- tests
    task automatic test_reset();
        drive_idle();
        RST_N = 0;
        exp_q.delete();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if ({out_a, out_b, out_imm, out_dst, out_op} !== '0) begin
            n_err++; $display("FAIL reset_data got a=%h b=%h imm=%h dst=%h op=%h exp all 0",
                              out_a, out_b, out_imm, out_dst, out_op);
        end
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1;
    endtask

    task automatic test_basic();
        drive_idle();
        out_ready = 1;
        drive_instr(3'd3, 3'd5, 3'd1, 4'h2, 8'h00, 8'h11, 8'h22);
        n_cmp++; if (RA1 !== 3'd3 || RA2 !== 3'd5) begin n_err++; $display("FAIL basic_ra got=%0d/%0d exp=3/5", RA1, RA2); end
        cycle();
        in_valid = 0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_a !== 8'h11 || out_b !== 8'h22) begin n_err++; $display("FAIL basic_ops got=%h/%h exp=11/22", out_a, out_b); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_bypass();
        drive_idle();
        out_ready = 1;
        drive_instr(3'd4, 3'd0, 3'd2, 4'h3, 8'h00, 8'h10, 8'h55);
        WB_WE = 1; WB_WA = 3'd4; WB_WD = 8'hAB;
        cycle();
        n_cmp++; if (out_a !== 8'hAB) begin n_err++; $display("FAIL bypass_a got=%h exp=ab", out_a); end
        n_cmp++; if (out_b !== 8'h00) begin n_err++; $display("FAIL bypass_src0_b got=%h exp=00", out_b); end
        drive_instr(3'd0, 3'd7, 3'd2, 4'h3, 8'h00, 8'h77, 8'h66);
        WB_WE = 1; WB_WA = 3'd0; WB_WD = 8'h99;
        cycle();
        n_cmp++; if (out_a !== 8'h00) begin n_err++; $display("FAIL bypass_r0_a got=%h exp=00", out_a); end
        n_cmp++; if (out_b !== 8'h66) begin n_err++; $display("FAIL bypass_nomatch_b got=%h exp=66", out_b); end
        drive_idle();
        out_ready = 1;
        cycle();
    endtask

    task automatic test_backpressure();
        drive_idle();
        drive_instr(3'd1, 3'd2, 3'd1, 4'h1, 8'hA1, 8'h0A, 8'h0B);
        cycle();
        drive_instr(3'd3, 3'd4, 3'd2, 4'h2, 8'hB2, 8'h1A, 8'h1B);
        cycle();
        in_valid = 0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || out_imm !== 8'hA1 || out_a !== 8'h0A) begin
            n_err++; $display("FAIL bp_head_A got=v%b imm=%h a=%h exp=v1 imm=a1 a=0a", out_valid, out_imm, out_a);
        end
        // Offered input while FULL must be ignored.
        drive_instr(3'd5, 3'd5, 3'd5, 4'h5, 8'hEE, 8'hEE, 8'hEE);
        cycle();
        in_valid = 0;
        n_cmp++; if (out_imm !== 8'hA1 || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold got=imm %h rdy %b exp=imm a1 rdy 0", out_imm, in_ready); end
        out_ready = 1;
        cycle();
        n_cmp++; if (out_valid !== 1'b1 || out_imm !== 8'hB2 || out_a !== 8'h1A || out_b !== 8'h1B) begin
            n_err++; $display("FAIL bp_head_B got=v%b imm=%h a=%h b=%h exp=v1 imm=b2 a=1a b=1b", out_valid, out_imm, out_a, out_b);
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_snoop();
        drive_idle();
        drive_instr(3'd1, 3'd2, 3'd1, 4'h1, 8'hA1, 8'h0A, 8'h0B);
        cycle();
        drive_instr(3'd3, 3'd6, 3'd2, 4'h2, 8'hB2, 8'h1A, 8'h01);
        cycle();
        in_valid = 0;
        WB_WE = 1; WB_WA = 3'd6; WB_WD = 8'h5C;
        cycle();
        WB_WE = 0;
        n_cmp++; if (out_imm !== 8'hA1 || out_b !== 8'h0B) begin n_err++; $display("FAIL snoop_head_kept got=imm %h b %h exp=imm a1 b 0b", out_imm, out_b); end
        // Writeback to register 0 must not touch anything (src of A is 1/2).
        WB_WE = 1; WB_WA = 3'd0; WB_WD = 8'hFF;
        cycle();
        WB_WE = 0;
        // Writeback on the edge where A leaves and B moves to the output.
        out_ready = 1;
        WB_WE = 1; WB_WA = 3'd3; WB_WD = 8'h3C;
        cycle();
        WB_WE = 0;
        out_ready = 0;
        n_cmp++; if (out_imm !== 8'hB2 || out_b !== 8'h5C || out_a !== 8'h3C) begin
            n_err++; $display("FAIL snoop_b got=imm %h a %h b %h exp=imm b2 a 3c b 5c", out_imm, out_a, out_b);
        end
        out_ready = 1;
        cycle();
    endtask

    task automatic test_flush();
        drive_idle();
        drive_instr(3'd1, 3'd1, 3'd1, 4'h1, 8'h01, 8'h01, 8'h01);
        cycle();
        drive_instr(3'd2, 3'd2, 3'd2, 4'h2, 8'h02, 8'h02, 8'h02);
        cycle();
        drive_instr(3'd3, 3'd3, 3'd3, 4'h3, 8'h03, 8'h03, 8'h03);
        FLUSH = 1; out_ready = 1;
        cycle();
        FLUSH = 0;
        in_valid = 0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_state got=v%b r%b exp=v0 r1", out_valid, in_ready); end
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_capture got=%b exp=0", out_valid); end
    endtask

    task automatic test_async_reset();
        drive_idle();
        drive_instr(3'd1, 3'd1, 3'd1, 4'h1, 8'h31, 8'h31, 8'h31);
        cycle();
        drive_instr(3'd2, 3'd2, 3'd2, 4'h2, 8'h32, 8'h32, 8'h32);
        cycle();
        in_valid = 0;
        #2;
        RST_N = 0;
        exp_q.delete();
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL async_rst got=v%b r%b exp=v0 r1", out_valid, in_ready); end
        n_cmp++; if (out_a !== 8'h00 || out_imm !== 8'h00) begin n_err++; $display("FAIL async_rst_data got=a %h imm %h exp=00", out_a, out_imm); end
        #1;
        RST_N = 1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_err;
        drive_idle();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_src1   = AW'($urandom_range(0, 7));
            in_src2   = AW'($urandom_range(0, 7));
            in_dst    = AW'($urandom_range(0, 7));
            in_op     = OPW'($urandom_range(0, 15));
            in_imm    = DW'($urandom_range(0, 255));
            RD1       = DW'($urandom_range(0, 255));
            RD2       = DW'($urandom_range(0, 255));
            WB_WE     = ($urandom_range(0, 1) == 1);
            WB_WA     = AW'($urandom_range(0, 7));
            WB_WD     = DW'($urandom_range(0, 255));
            FLUSH     = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 2) == 0);
            #1;
            n_cmp++; if (RA1 !== in_src1 || RA2 !== in_src2) begin n_err++; $display("FAIL rnd_ra c=%0d got=%0d/%0d exp=%0d/%0d", c, RA1, RA2, in_src1, in_src2); end
            cycle();
            n_cmp++; if (out_valid !== (exp_q.size() > 0)) begin n_err++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_q.size() > 0); end
            n_cmp++; if (in_ready !== (exp_q.size() < 2)) begin n_err++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_q.size() < 2); end
            if (exp_q.size() > 0) begin
                n_cmp++;
                if (out_a !== exp_q[0].a || out_b !== exp_q[0].b || out_dst !== exp_q[0].dst ||
                    out_op !== exp_q[0].op || out_imm !== exp_q[0].imm) begin
                    n_err++;
                    $display("FAIL rnd_data c=%0d got=a%h b%h d%0d o%h i%h exp=a%h b%h d%0d o%h i%h", c,
                             out_a, out_b, out_dst, out_op, out_imm,
                             exp_q[0].a, exp_q[0].b, exp_q[0].dst, exp_q[0].op, exp_q[0].imm);
                end
            end
            if (n_err - errs_before > 10) break;
        end
        drive_idle();
    endtask

    // ---------------------------------------------------------- sequence
    initial begin
        drive_idle();
        test_reset();
        test_basic();
        test_bypass();
        test_backpressure();
        test_snoop();
        test_flush();
        test_async_reset();
        do_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
